// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the round datapath.
package aes_pkg;

    localparam int unsigned STATE_W = 128;
    localparam int unsigned COL_W   = 32;
    localparam int unsigned BYTE_W  = 8;

    // Reduction term for the field polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [BYTE_W-1:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        HOLD    = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8).
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column; byte a0 sits in the top byte.
module mix_single_column (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);
    import aes_pkg::*;

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;   // 2*a
    logic [7:0] t0, t1, t2, t3;   // 3*a

    assign {a0, a1, a2, a3} = col_in;

    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);

    assign t0 = d0 ^ a0;
    assign t1 = d1 ^ a1;
    assign t2 = d2 ^ a2;
    assign t3 = d3 ^ a3;

    assign col_out = {d0 ^ t1 ^ a2 ^ a3,
                      a0 ^ d1 ^ t2 ^ a3,
                      a0 ^ a1 ^ d2 ^ t3,
                      t0 ^ a1 ^ a2 ^ d3};

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns stage: capture one state, transform a column per
// clock through a single shared column unit, then hold the result until taken.
module mix_columns_seq #(
    parameter int unsigned STATE_W = 128,
    parameter int unsigned COL_W   = 32
) (
    input  logic               clock50MHz,
    input  logic               resetN,
    input  logic [STATE_W-1:0] inputData,
    input  logic               inValid,
    output logic               inReady,
    input  logic               bypassMix,
    output logic [STATE_W-1:0] outputData,
    output logic               outValid,
    input  logic               outReady
);
    import aes_pkg::*;

    mc_state_e          fsm_q, fsm_d;
    logic [1:0]         col_q, col_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic               bypass_q, bypass_d;
    logic [COL_W-1:0]   col_in, col_out;

    mix_single_column u_mix_col (
        .col_in  (col_in),
        .col_out (col_out)
    );

    // Select the column currently being transformed (column 0 is the top word).
    always_comb begin
        col_in = '0;
        unique case (col_q)
            2'd0: col_in = state_q[127:96];
            2'd1: col_in = state_q[95:64];
            2'd2: col_in = state_q[63:32];
            2'd3: col_in = state_q[31:0];
            default: col_in = '0;
        endcase
    end

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        fsm_d    = fsm_q;
        col_d    = col_q;
        state_d  = state_q;
        bypass_d = bypass_q;
        inReady  = 1'b0;
        outValid = 1'b0;

        unique case (fsm_q)
            IDLE: begin
                inReady = 1'b1;
                // Only a real transfer touches the state, so X on idle data stays out.
                if (inValid) begin
                    state_d  = inputData;
                    bypass_d = bypassMix;
                    col_d    = 2'd0;
                    fsm_d    = bypassMix ? HOLD : COMPUTE;
                end
            end
            COMPUTE: begin
                if (!bypass_q) begin
                    unique case (col_q)
                        2'd0: state_d[127:96] = col_out;
                        2'd1: state_d[95:64]  = col_out;
                        2'd2: state_d[63:32]  = col_out;
                        2'd3: state_d[31:0]   = col_out;
                        default: ;
                    endcase
                end
                if (col_q == 2'd3) begin
                    col_d = 2'd0;
                    fsm_d = HOLD;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            HOLD: begin
                outValid = 1'b1;
                // Single slot: the upstream waits for the IDLE cycle after this.
                if (outReady) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset; reset aborts any transform.
    always_ff @(posedge clock50MHz) begin
        if (!resetN) begin
            fsm_q    <= IDLE;
            col_q    <= 2'd0;
            state_q  <= '0;
            bypass_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            col_q    <= col_d;
            state_q  <= state_d;
            bypass_q <= bypass_d;
        end
    end

    assign outputData = state_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: directed known answers, latency,
// backpressure, reset abort, and a randomized scoreboard run.
module tb_mix_columns_seq;

    logic         clock50MHz;
    logic         resetN;
    logic [127:0] inputData;
    logic         inValid;
    logic         inReady;
    logic         bypassMix;
    logic [127:0] outputData;
    logic         outValid;
    logic         outReady;

    mix_columns_seq #(
        .STATE_W (128),
        .COL_W   (32)
    ) dut (
        .clock50MHz (clock50MHz),
        .resetN     (resetN),
        .inputData  (inputData),
        .inValid    (inValid),
        .inReady    (inReady),
        .bypassMix  (bypassMix),
        .outputData (outputData),
        .outValid   (outValid),
        .outReady   (outReady)
    );

    initial clock50MHz = 1'b0;
    always #10 clock50MHz = ~clock50MHz;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int n_out     = 0;
    logic [127:0] sb[$];

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] BYP_IN   = 128'h6353e08c0960e104cd70b751bacad0e7;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply for the reference model.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a[4];
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            r[127 - 32*c      -: 8] = gmul(a[0], 2) ^ gmul(a[1], 3) ^ a[2] ^ a[3];
            r[127 - 32*c - 8  -: 8] = a[0] ^ gmul(a[1], 2) ^ gmul(a[2], 3) ^ a[3];
            r[127 - 32*c - 16 -: 8] = a[0] ^ a[1] ^ gmul(a[2], 2) ^ gmul(a[3], 3);
            r[127 - 32*c - 24 -: 8] = gmul(a[0], 3) ^ a[1] ^ a[2] ^ gmul(a[3], 2);
        end
        return r;
    endfunction

    // Output monitor: a transfer happens at the next posedge when both are high.
    always @(negedge clock50MHz) begin
        if (resetN === 1'b1 && outValid === 1'b1 && outReady === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", outputData, 128'hx);
            end else begin
                check("out_data", outputData, sb.pop_front());
                n_out++;
            end
        end
    end

    // Offer a state (called just after a posedge); data goes X and bypass flips after capture.
    task automatic send(input logic [127:0] d, input logic byp, input logic [127:0] exp);
        int n = 0;
        inValid   = 1'b1;
        inputData = d;
        bypassMix = byp;
        sb.push_back(exp);
        @(negedge clock50MHz);
        while (inReady !== 1'b1 && n < 200) begin
            @(negedge clock50MHz);
            n++;
        end
        if (inReady !== 1'b1) check("send_timeout", {127'b0, inReady}, 128'd1);
        @(posedge clock50MHz);
        #2;
        inValid   = 1'b0;
        inputData = 'x;
        bypassMix = ~byp;
    endtask

    // Count negedges after the capture edge until outValid rises (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clock50MHz);
            lat++;
        end while (outValid !== 1'b1 && lat < 200);
        if (outValid !== 1'b1) check("valid_timeout", {127'b0, outValid}, 128'd1);
    endtask

    task automatic step;
        @(posedge clock50MHz);
        #2;
    endtask

    initial begin
        int lat;
        int base_out;
        logic [127:0] d;
        logic byp;
        bit done;
        logic [31:0] kin[4];
        logic [31:0] kout[4];
        kin  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        kout = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};

        resetN    = 1'b0;
        inValid   = 1'b0;
        inputData = 'x;
        bypassMix = 1'b0;
        outReady  = 1'b1;
        step;
        step;
        resetN = 1'b1;
        @(negedge clock50MHz);
        check("rst_outValid", {127'b0, outValid}, 128'd0);
        check("rst_inReady", {127'b0, inReady}, 128'd1);
        check("rst_outputData", outputData, 128'd0);
        step;

        // FIPS-197 round vector, latency and return to IDLE.
        send(FIPS_IN, 1'b0, FIPS_OUT);
        @(negedge clock50MHz);
        check("compute_inReady", {127'b0, inReady}, 128'd0);
        lat = 1;
        while (outValid !== 1'b1 && lat < 200) begin
            @(negedge clock50MHz);
            lat++;
        end
        check("fips_latency", lat, 5);
        check("fips_data", outputData, FIPS_OUT);
        step;
        @(negedge clock50MHz);
        check("fips_idle_inReady", {127'b0, inReady}, 128'd1);
        check("fips_idle_outValid", {127'b0, outValid}, 128'd0);
        step;

        // Single-column known answers placed in column 2.
        for (int i = 0; i < 4; i++) begin
            send({64'h0, kin[i], 32'h0}, 1'b0, {64'h0, kout[i], 32'h0});
            wait_valid(lat);
            check("col2_latency", lat, 5);
            step;
        end

        // Bypass passes the state unchanged after one edge.
        send(BYP_IN, 1'b1, BYP_IN);
        wait_valid(lat);
        check("bypass_latency", lat, 1);
        check("bypass_data", outputData, BYP_IN);
        step;

        // Backpressure with a second state queued behind the held one.
        outReady = 1'b0;
        send(FIPS_IN, 1'b0, FIPS_OUT);
        wait_valid(lat);
        check("bp_latency", lat, 5);
        d = ref_mix(BYP_IN);
        inValid   = 1'b1;
        inputData = BYP_IN;
        bypassMix = 1'b0;
        sb.push_back(d);
        for (int i = 0; i < 10; i++) begin
            step;
            @(negedge clock50MHz);
            check("bp_hold_data", outputData, FIPS_OUT);
            check("bp_inReady", {127'b0, inReady}, 128'd0);
        end
        step;
        outReady = 1'b1;
        step;
        @(negedge clock50MHz);
        check("bp_released_inReady", {127'b0, inReady}, 128'd1);
        check("bp_released_outValid", {127'b0, outValid}, 128'd0);
        @(posedge clock50MHz);
        #2;
        inValid   = 1'b0;
        inputData = 'x;
        wait_valid(lat);
        check("bp_second_latency", lat, 5);
        step;

        // Reset during COMPUTE at col=2 aborts with no output.
        send(FIPS_IN, 1'b0, FIPS_OUT);
        step;
        step;
        resetN = 1'b0;
        step;
        resetN = 1'b1;
        sb.delete();
        @(negedge clock50MHz);
        check("abort_outValid", {127'b0, outValid}, 128'd0);
        check("abort_outputData", outputData, 128'd0);
        check("abort_inReady", {127'b0, inReady}, 128'd1);
        step;
        send(FIPS_IN, 1'b0, FIPS_OUT);
        wait_valid(lat);
        check("after_abort_latency", lat, 5);
        step;

        // Randomized back-to-back traffic with stalls on both sides.
        base_out = n_out;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) step;
                    d   = {$urandom, $urandom, $urandom, $urandom};
                    byp = ($urandom_range(0, 3) == 0);
                    send(d, byp, byp ? d : ref_mix(d));
                end
                for (int i = 0; i < 400 && sb.size() != 0; i++) step;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    step;
                    outReady = ($urandom_range(0, 3) != 0);
                end
                outReady = 1'b1;
            end
        join
        check("rand_drained", sb.size(), 0);
        check("rand_count", n_out - base_out, 1000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Column-serial AES MixColumns stage. It sits directly downstream of shift_row and upstream of add_round_key in the round datapath.
- Accepts one 128-bit state through a valid/ready handshake and transforms one 32-bit column per clock. It holds the result until the consumer accepts it.
- A bypass input passes the state through unchanged for the final AES round, which has no MixColumns.

Parameters:
- STATE_W, 128, state width in bits; fixed to 128, present for package consistency.
- COL_W, 32, column width in bits.

Ports:
- clock50MHz  input  1  system clock, 50 MHz.
- resetN  input  1  reset; one clock, synchronous, active-low.
- inputData  input  128  state from shift_row; byte 0 = [127:120], column c = bytes 4c..4c+3 (column 0 = [127:96]).
- inValid  input  1  inputData/bypassMix valid.
- inReady  output  1  block can accept a state.
- bypassMix  input  1  sampled with the state; 1 = output equals input (final round).
- outputData  output  128  transformed state.
- outValid  output  1  outputData valid.
- outReady  input  1  consumer accepts outputData.

Behaviour:
- Reset (resetN=0 at a clock edge):
  - FSM goes to IDLE; column counter = 0; state register = 0.
  - Outputs: outputData = 0, outValid = 0, inReady = 1 from the next cycle.
  - Reset takes priority over every other event and aborts any transform in progress, with no output produced.
- FSM states:
  - IDLE: inReady=1, outValid=0.
    - inValid=1 captures inputData into the state register and bypassMix into bypassReg.
    - If bypassMix=0, go to COMPUTE with col=0.
    - If bypassMix=1, go to HOLD.
  - COMPUTE: inReady=0, outValid=0.
    - Each cycle, column col of the state register is replaced by its MixColumns result.
    - col increments 0→1→2→3. When col=3, go to HOLD and wrap col to 0.
  - HOLD: outValid=1, inReady=0, outputData = state register, held stable.
    - On outReady=1, go to IDLE.
    - No input is accepted in the same cycle; the stage holds a single slot, and throughput is 1 state per 6 cycles (non-bypass).
- Latency:
  - Capture edge at cycle T; outValid=1 from cycle T+5 (one capture edge, four compute edges).
  - Bypass: outValid=1 from cycle T+1.
- Column math, GF(2^8) with polynomial 0x11B:
  - xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
  - 3x = xtime(x)^x. All results are 8 bits; there is no carry beyond xtime.
- Handshake rules:
  - A transfer happens when valid and ready are both 1 at a clock edge.
  - While outValid=1, outputData must not change until the transfer completes.
  - outReady held high before outValid is legal and completes the transfer on the first HOLD cycle.
  - inValid during COMPUTE/HOLD is ignored (inReady=0); the upstream block must hold its data.
- Boundary conditions:
  - inValid and outReady both high in HOLD: only the output transfer occurs; the input is taken in the following IDLE cycle.
  - bypassMix changing after capture has no effect on the current state.
  - X on inputData while inValid=0 must not propagate into the state register.

Decomposition:
- Shared package/header aes_pkg holds:
  - STATE_W, COL_W, BYTE_W constants.
  - AES_POLY = 8'h1B.
  - xtime function.
  - FSM state encodings: IDLE=2'd0, COMPUTE=2'd1, HOLD=2'd2.
- One combinational sub-module: mix_single_column (32-bit in → 32-bit out, using xtime from aes_pkg).
  - It is instantiated once and muxed by col.
  - It is also reused later by the inverse path's test bench.

Test Plan:
- Full FIPS-197 round vector: inputData=d4bf5d30e0b452aeb84111f11e2798e5, bypassMix=0, outReady=1 → outValid at T+5, outputData=046681e5e0cb199a48f8d37a2806264c, then inReady=1 the next cycle.
- Single-column known answers in column 2, other columns 0:
  - db135345 → 8e4da1bc
  - f20a225c → 9fdc589d
  - 01010101 → 01010101
  - c6c6c6c6 → c6c6c6c6
- Bypass: inputData=6353e08c0960e104cd70b751bacad0e7, bypassMix=1 → outValid at T+1, outputData identical to input.
- Backpressure: outReady=0 for 10 cycles after outValid → outputData stable and inReady=0 throughout; outReady=1 → IDLE next cycle; a second queued state is accepted only after that.
- Reset mid-operation: resetN=0 during COMPUTE (col=2) → next cycle outValid=0, outputData=0, inReady=1; a fresh vector then produces a correct result.
- Back-to-back random states (≥1000) against a reference model with random outValid/outReady stalls → every output matches and no states are dropped or duplicated.
